// File: rtl/nv_nvdla_cacc_mac_merge_pkg.sv
// Shared constants for the CACC MAC merge stage.
// Optional build macro: NVDLA_CACC_MERGE_PERF_EN.
package nv_nvdla_cacc_mac_merge_pkg;

   localparam int STRIPE_ST   = 0;
   localparam int STRIPE_END  = 1;
   localparam int CHANNEL_END = 2;
   localparam int LAYER_END   = 3;
   localparam int PD_WIDTH    = 9;

   function automatic int entry_width(input int atomk_half, input int result_width);
      return 1 + PD_WIDTH + atomk_half + atomk_half * result_width;
   endfunction

endpackage

// File: rtl/nv_nvdla_cacc_mac_merge_fifo.sv
// Flop-based synchronous FIFO for one CMAC side of the merge stage.
// Used with NVDLA_CACC_MERGE_PERF_EN on or off; no macro-dependent logic here.
module nv_nvdla_cacc_merge_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic             drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_ptr[AW] != rd_ptr[AW]);

   // A pop on the same edge frees the slot the push lands in.
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign drop  = push & full & ~rd_en;
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/nv_nvdla_cacc_mac_merge.sv
// Pairs CMAC A/B half-stripe beats into one full-ATOMK accumulator word.
// Define NVDLA_CACC_MERGE_PERF_EN to add the perf_skew_cnt counter.
module nv_nvdla_cacc_mac_merge
   import nv_nvdla_cacc_mac_merge_pkg::*;
#(
   parameter int ATOMK_HALF   = 8,
   parameter int RESULT_WIDTH = 19,
   parameter int DEPTH        = 4
) (
   input  logic                                nvdla_core_clk,
   input  logic                                nvdla_core_rstn,
   input  logic                                mac_a2accu_pvld,
   input  logic [ATOMK_HALF-1:0]               mac_a2accu_mask,
   input  logic                                mac_a2accu_mode,
   input  logic [ATOMK_HALF*RESULT_WIDTH-1:0]  mac_a2accu_data,
   input  logic [PD_WIDTH-1:0]                 mac_a2accu_pd,
   input  logic                                mac_b2accu_pvld,
   input  logic [ATOMK_HALF-1:0]               mac_b2accu_mask,
   input  logic                                mac_b2accu_mode,
   input  logic [ATOMK_HALF*RESULT_WIDTH-1:0]  mac_b2accu_data,
   input  logic [PD_WIDTH-1:0]                 mac_b2accu_pd,
   output logic                                accu_pvld,
   output logic [2*ATOMK_HALF-1:0]             accu_mask,
   output logic                                accu_mode,
   output logic [2*ATOMK_HALF*RESULT_WIDTH-1:0] accu_data,
   output logic [PD_WIDTH-1:0]                 accu_pd,
   input  logic                                err_clr,
   output logic                                err_overflow,
   output logic                                err_mismatch
`ifdef NVDLA_CACC_MERGE_PERF_EN
   ,
   output logic [31:0]                         perf_skew_cnt
`endif
);

   localparam int HW = ATOMK_HALF * RESULT_WIDTH;
   localparam int EW = entry_width(ATOMK_HALF, RESULT_WIDTH);

   logic [EW-1:0]         rd_a;
   logic [EW-1:0]         rd_b;
   logic                  full_a;
   logic                  full_b;
   logic                  empty_a;
   logic                  empty_b;
   logic                  drop_a;
   logic                  drop_b;
   logic                  pop;
   logic                  mis_set;
   logic                  ovf_set;
   logic                  unused_full;
   logic [HW-1:0]         zdata_a;
   logic [HW-1:0]         zdata_b;
   logic [ATOMK_HALF-1:0] mask_a;
   logic [ATOMK_HALF-1:0] mask_b;
   logic [PD_WIDTH-1:0]   pd_a;
   logic [PD_WIDTH-1:0]   pd_b;
   logic                  mode_a;
   logic                  mode_b;

   assign pop = ~empty_a & ~empty_b;

   nv_nvdla_cacc_merge_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo_a (
      .clk   (nvdla_core_clk),
      .rst_n (nvdla_core_rstn),
      .push  (mac_a2accu_pvld),
      .pop   (pop),
      .wdata ({mac_a2accu_mode, mac_a2accu_pd,
               mac_a2accu_mask, mac_a2accu_data}),
      .rdata (rd_a),
      .full  (full_a),
      .empty (empty_a),
      .drop  (drop_a)
   );

   nv_nvdla_cacc_merge_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo_b (
      .clk   (nvdla_core_clk),
      .rst_n (nvdla_core_rstn),
      .push  (mac_b2accu_pvld),
      .pop   (pop),
      .wdata ({mac_b2accu_mode, mac_b2accu_pd,
               mac_b2accu_mask, mac_b2accu_data}),
      .rdata (rd_b),
      .full  (full_b),
      .empty (empty_b),
      .drop  (drop_b)
   );

   assign unused_full = full_a ^ full_b;

   assign mask_a = rd_a[HW +: ATOMK_HALF];
   assign mask_b = rd_b[HW +: ATOMK_HALF];
   assign pd_a   = rd_a[HW+ATOMK_HALF +: PD_WIDTH];
   assign pd_b   = rd_b[HW+ATOMK_HALF +: PD_WIDTH];
   assign mode_a = rd_a[EW-1];
   assign mode_b = rd_b[EW-1];

   always_comb begin
      zdata_a = '0;
      zdata_b = '0;
      for (int i = 0; i < ATOMK_HALF; i++) begin
         if (mask_a[i])
            zdata_a[i*RESULT_WIDTH +: RESULT_WIDTH] =
               rd_a[i*RESULT_WIDTH +: RESULT_WIDTH];
         if (mask_b[i])
            zdata_b[i*RESULT_WIDTH +: RESULT_WIDTH] =
               rd_b[i*RESULT_WIDTH +: RESULT_WIDTH];
      end
   end

   assign mis_set = pop & ((pd_a != pd_b) | (mode_a != mode_b));
   assign ovf_set = drop_a | drop_b;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         accu_pvld <= 1'b0;
         accu_mask <= '0;
         accu_mode <= 1'b0;
         accu_data <= '0;
         accu_pd   <= '0;
      end else begin
         accu_pvld <= pop;
         if (pop) begin
            accu_mask <= {mask_b, mask_a};
            accu_mode <= mode_a;
            accu_data <= {zdata_b, zdata_a};
            accu_pd   <= pd_a;
         end
      end
   end

   // A set event in the clear cycle keeps the flag high.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         err_overflow <= 1'b0;
         err_mismatch <= 1'b0;
      end else begin
         err_overflow <= ovf_set | (err_overflow & ~err_clr);
         err_mismatch <= mis_set | (err_mismatch & ~err_clr);
      end
   end

`ifdef NVDLA_CACC_MERGE_PERF_EN
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn)
         perf_skew_cnt <= '0;
      else if (err_clr)
         perf_skew_cnt <= '0;
      else if ((empty_a ^ empty_b) && (perf_skew_cnt != 32'hFFFF_FFFF))
         perf_skew_cnt <= perf_skew_cnt + 32'd1;
   end
`endif

endmodule
